// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: core-wide PC defaults, FSM state
// encoding and the redirect priority used when a fetch is acknowledged.
package pc_sequencer_pkg;

    // Core-wide defaults, shared with the PC Adder.
    localparam int          PC_W_DEF         = 8;
    localparam logic [7:0]  RESET_VECTOR_DEF = 8'h00;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_STALL = 2'd2,
        ST_ERR   = 2'd3
    } seqStateT;

    // Redirect kinds, highest priority first: RET > CALL > BRANCH > SEQ.
    typedef enum logic [1:0] {
        REDIR_SEQ    = 2'd0,
        REDIR_BRANCH = 2'd1,
        REDIR_CALL   = 2'd2,
        REDIR_RET    = 2'd3
    } redirT;

    // Resolve the redirect lines of an acknowledged fetch into a single kind.
    function automatic redirT redirSelect(input logic ret, input logic call,
                                          input logic branch);
        if (ret)         return REDIR_RET;
        else if (call)   return REDIR_CALL;
        else if (branch) return REDIR_BRANCH;
        else             return REDIR_SEQ;
    endfunction

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Hardware return stack: small LIFO of return addresses with full/empty
// status, same-cycle overflow/underflow detection and a sticky error flag.
// An overflowing push or underflowing pop leaves the contents untouched.
module pc_return_stack
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] pushData,
    output logic [PC_W-1:0] top,
    output logic            full,
    output logic            empty,
    output logic            opErr,
    output logic            err
);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0] mem [STACK_DEPTH];
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   wrIdx;
    logic [AW-1:0]   topIdx;

    assign full   = (cnt == CW'(STACK_DEPTH));
    assign empty  = (cnt == '0);
    assign wrIdx  = cnt[AW-1:0];
    assign topIdx = cnt[AW-1:0] - AW'(1);
    assign top    = mem[topIdx];
    // Flags the offending operation in the same cycle so the FSM can divert.
    assign opErr  = (push && full) || (pop && empty);

    // Entry storage; written only on a legal push.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wrIdx] <= pushData;
    end

    // Occupancy counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (push && !full)       cnt <= cnt + CW'(1);
            else if (pop && !empty)  cnt <= cnt - CW'(1);
            if (opErr)               err <= 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer. Drives the external PC Adder with
// PC and +1, issues fetch requests with a req/ack handshake and applies
// return/call/branch redirects on the acknowledged cycle.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              PC_W         = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(RESET_VECTOR_DEF),
    parameter int              STACK_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iStall,
    input  logic            iFetchAck,
    input  logic            iBranch,
    input  logic            iCall,
    input  logic            iRet,
    input  logic [PC_W-1:0] iTarget,
    output logic [PC_W-1:0] oAdderA,
    output logic [PC_W-1:0] oAdderB,
    input  logic [PC_W-1:0] iAdderSum,
    output logic [PC_W-1:0] oPC,
    output logic            oFetchReq,
    output logic            oInstrValid,
    output logic            oStackErr
);
    seqStateT        state, stateNext;
    logic [PC_W-1:0] pc, pcNext;
    logic            instrValidNext;
    logic            push, pop;
    logic [PC_W-1:0] stackTop;
    logic            stackFull, stackEmpty, stackOpErr;
    redirT           redir;

    assign oAdderA = pc;
    assign oAdderB = PC_W'(1);
    assign oPC     = pc;
    assign redir   = redirSelect(iRet, iCall, iBranch);

    pc_return_stack #(
        .PC_W       (PC_W),
        .STACK_DEPTH(STACK_DEPTH)
    ) uStack (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .pushData(iAdderSum),
        .top     (stackTop),
        .full    (stackFull),
        .empty   (stackEmpty),
        .opErr   (stackOpErr),
        .err     (oStackErr)
    );

    // Next state, next PC and stack operation for the current cycle.
    always_comb begin
        stateNext      = state;
        pcNext         = pc;
        instrValidNext = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;
        case (state)
            ST_BOOT: stateNext = ST_FETCH;
            ST_FETCH: begin
                if (iFetchAck) begin
                    instrValidNext = 1'b1;
                    case (redir)
                        REDIR_RET: begin
                            pop    = 1'b1;
                            pcNext = stackTop;
                        end
                        REDIR_CALL: begin
                            push   = 1'b1;
                            pcNext = iTarget;
                        end
                        REDIR_BRANCH: pcNext = iTarget;
                        default:      pcNext = iAdderSum;
                    endcase
                    // A stack fault freezes the PC and parks the sequencer.
                    if (stackOpErr) begin
                        pcNext    = pc;
                        stateNext = ST_ERR;
                    end else begin
                        stateNext = iStall ? ST_STALL : ST_FETCH;
                    end
                end else if (iStall) begin
                    stateNext = ST_STALL;
                end
            end
            ST_STALL: if (!iStall) stateNext = ST_FETCH;
            default:  stateNext = ST_ERR;
        endcase
    end

    // State, PC and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_BOOT;
            pc          <= RESET_VECTOR;
            oFetchReq   <= 1'b0;
            oInstrValid <= 1'b0;
        end else begin
            state       <= stateNext;
            pc          <= pcNext;
            oFetchReq   <= (stateNext == ST_FETCH);
            oInstrValid <= instrValidNext;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural PC Adder.
module tb_pc_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       iStall, iFetchAck, iBranch, iCall, iRet;
    logic [7:0] iTarget;
    logic [7:0] oAdderA, oAdderB, iAdderSum, oPC;
    logic       oFetchReq, oInstrValid, oStackErr;

    int nChecks = 0;
    int nErrs   = 0;

    always #5 clk = ~clk;

    // External 8-bit adder: wraps modulo 256.
    assign iAdderSum = oAdderA + oAdderB;

    pc_sequencer #(.PC_W(8), .RESET_VECTOR(8'h00), .STACK_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .iStall     (iStall),
        .iFetchAck  (iFetchAck),
        .iBranch    (iBranch),
        .iCall      (iCall),
        .iRet       (iRet),
        .iTarget    (iTarget),
        .oAdderA    (oAdderA),
        .oAdderB    (oAdderB),
        .iAdderSum  (iAdderSum),
        .oPC        (oPC),
        .oFetchReq  (oFetchReq),
        .oInstrValid(oInstrValid),
        .oStackErr  (oStackErr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ack, input logic br, input logic call,
                         input logic ret, input logic [7:0] tgt, input logic stall);
        iFetchAck = ack;
        iBranch   = br;
        iCall     = call;
        iRet      = ret;
        iTarget   = tgt;
        iStall    = stall;
    endtask

    // Reset, check reset state, then step out of BOOT into FETCH.
    task automatic doReset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 8'h00, 0);
        tick();
        chk("rst pc", oPC, 8'h00);
        chk("rst req", oFetchReq, 0);
        chk("rst valid", oInstrValid, 0);
        chk("rst err", oStackErr, 0);
        rst = 1'b0;
        tick();
        chk("boot->fetch req", oFetchReq, 1);
        chk("boot valid", oInstrValid, 0);
    endtask

    // One acknowledged fetch with the given redirects.
    task automatic ackStep(input logic br, input logic call, input logic ret,
                           input logic [7:0] tgt);
        drive(1, br, call, ret, tgt, 0);
        tick();
        drive(0, 0, 0, 0, 8'h00, 0);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 8'h00, 0);

        // Sequential fetches from reset.
        doReset();
        chk("seq pc0", oPC, 8'h00);
        for (int i = 1; i <= 4; i++) begin
            drive(1, 0, 0, 0, 8'h00, 0);
            tick();
            chk($sformatf("seq pc%0d", i), oPC, i);
            chk("seq valid", oInstrValid, 1);
            chk("seq req", oFetchReq, 1);
            chk("adderA", oAdderA, i);
            chk("adderB", oAdderB, 1);
        end
        drive(0, 0, 0, 0, 8'h00, 0);
        tick();
        chk("hold pc", oPC, 8'h04);
        chk("hold valid", oInstrValid, 0);
        chk("hold req", oFetchReq, 1);

        // Wrap at 8'hFF.
        ackStep(1, 0, 0, 8'hFE);
        chk("br FE", oPC, 8'hFE);
        ackStep(0, 0, 0, 8'h00);
        chk("wrap FF", oPC, 8'hFF);
        ackStep(0, 0, 0, 8'h00);
        chk("wrap 00", oPC, 8'h00);
        chk("wrap err", oStackErr, 0);

        // Branch, call, return.
        ackStep(1, 0, 0, 8'h40);
        chk("br 40", oPC, 8'h40);
        ackStep(0, 1, 0, 8'h80);
        chk("call 80", oPC, 8'h80);
        ackStep(0, 0, 1, 8'h00);
        chk("ret 41", oPC, 8'h41);
        chk("ret err", oStackErr, 0);

        // Priority: ret beats call and branch; then underflow.
        ackStep(1, 0, 0, 8'h11);
        ackStep(0, 1, 0, 8'h30);
        chk("call 30", oPC, 8'h30);
        ackStep(1, 1, 1, 8'h55);
        chk("prio ret pc", oPC, 8'h12);
        chk("prio err", oStackErr, 0);
        ackStep(0, 0, 1, 8'h00);
        chk("udf err", oStackErr, 1);
        chk("udf pc", oPC, 8'h12);
        chk("udf req", oFetchReq, 0);
        drive(1, 0, 0, 0, 8'h00, 0);
        tick();
        tick();
        chk("err hold pc", oPC, 8'h12);
        chk("err hold req", oFetchReq, 0);
        chk("err sticky", oStackErr, 1);

        // Overflow on the fifth nested call.
        doReset();
        ackStep(0, 1, 0, 8'h10);
        ackStep(0, 1, 0, 8'h20);
        ackStep(0, 1, 0, 8'h30);
        ackStep(0, 1, 0, 8'h40);
        chk("call4 pc", oPC, 8'h40);
        chk("call4 err", oStackErr, 0);
        ackStep(0, 1, 0, 8'h50);
        chk("ovf err", oStackErr, 1);
        chk("ovf pc", oPC, 8'h40);
        chk("ovf req", oFetchReq, 0);

        // Stall handling and reset during stall.
        doReset();
        chk("post-rst err", oStackErr, 0);
        ackStep(0, 0, 0, 8'h00);
        chk("st pc01", oPC, 8'h01);
        drive(0, 0, 0, 0, 8'h00, 1);
        tick();
        chk("stall req", oFetchReq, 0);
        chk("stall pc", oPC, 8'h01);
        drive(1, 1, 0, 0, 8'h77, 1);
        tick();
        chk("stall ack pc", oPC, 8'h01);
        chk("stall ack valid", oInstrValid, 0);
        chk("stall ack req", oFetchReq, 0);
        drive(0, 0, 0, 0, 8'h00, 0);
        tick();
        chk("resume req", oFetchReq, 1);
        chk("resume pc", oPC, 8'h01);
        ackStep(0, 0, 0, 8'h00);
        chk("resume ack pc", oPC, 8'h02);
        drive(1, 0, 0, 0, 8'h00, 1);
        tick();
        chk("ack+stall pc", oPC, 8'h03);
        chk("ack+stall req", oFetchReq, 0);
        chk("ack+stall valid", oInstrValid, 1);
        drive(0, 0, 0, 0, 8'h00, 1);
        rst = 1'b1;
        tick();
        chk("stall rst pc", oPC, 8'h00);
        chk("stall rst req", oFetchReq, 0);
        chk("stall rst valid", oInstrValid, 0);
        rst = 1'b0;
        iStall = 1'b0;
        tick();
        chk("stall rst boot", oFetchReq, 1);

        // Reset in the middle of a handshake discards the ack.
        ackStep(0, 0, 0, 8'h00);
        drive(1, 1, 0, 0, 8'h99, 0);
        rst = 1'b1;
        tick();
        chk("rst ack pc", oPC, 8'h00);
        chk("rst ack valid", oInstrValid, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 8'h00, 0);

        $display("Result: errors=%0d of %0d checks", nErrs, nChecks);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter register and fetch sequencer for the MAP core. It sits directly upstream of the 8-bit PC Adder: it drives the Adder's A/B inputs with PC and +1, and consumes the Adder's sum as the sequential next PC. It issues fetch requests to instruction memory with a req/ack handshake. It also applies branch, call and return redirects, using a small hardware return stack.

Parameters:
PC_W, 8, program counter width; must match the Adder width.
RESET_VECTOR, 8'h00, PC value loaded on reset.
STACK_DEPTH, 4, number of return-stack entries (power of 2, at least 2).

Ports:
clk  input  1  core clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
iStall  input  1  hold fetch; no new request while high
iFetchAck  input  1  instruction memory accepted and returned the word at oPC
iBranch  input  1  jump to iTarget; sampled only in the ack cycle
iCall  input  1  push return address, jump to iTarget; sampled only in the ack cycle
iRet  input  1  pop the return stack into PC; sampled only in the ack cycle
iTarget  input  PC_W  absolute branch/call target
oAdderA  output  PC_W  to Adder A; always equals the current PC
oAdderB  output  PC_W  to Adder B; constant 1
iAdderSum  input  PC_W  from Adder oData (PC+1, combinational, same cycle)
oPC  output  PC_W  fetch address
oFetchReq  output  1  fetch request to instruction memory
oInstrValid  output  1  one-cycle pulse, the cycle after an accepted fetch
oStackErr  output  1  sticky flag for stack overflow or underflow

Behaviour:
- Reset (rst=1 at a clock edge): PC=RESET_VECTOR, stack pointer=0, state=BOOT, oFetchReq=0, oInstrValid=0, oStackErr=0. Reset wins over every other input, including in the middle of a handshake. A pending ack is discarded.
- States:
  - BOOT: lasts one cycle, then goes to FETCH.
  - FETCH: oFetchReq=1.
  - STALL: oFetchReq=0.
  - ERR: oFetchReq=0. Exits only on reset.
- FETCH, iFetchAck=0, iStall=0: hold the PC and keep oFetchReq asserted.
- FETCH, iFetchAck=0, iStall=1: go to STALL. The PC holds.
- FETCH, iFetchAck=1: the handshake completes. oInstrValid=1 in the next cycle. The next PC is chosen by this priority:
  1. iRet: PC <= stack top; the pointer decrements.
  2. iCall: push iAdderSum, then PC <= iTarget.
  3. iBranch: PC <= iTarget.
  4. Otherwise: PC <= iAdderSum.
  - Lower-priority redirects asserted in the same cycle are ignored.
  - Next state is STALL if iStall=1, else FETCH.
- STALL: stay while iStall=1. On iStall=0, return to FETCH. Acks received in STALL are ignored. The PC holds.
- Return stack:
  - A push when the stack is full (STACK_DEPTH entries) is an overflow.
  - A pop when the stack is empty is an underflow.
  - Either case sets oStackErr=1 and sends the state to ERR. PC and stack are left unchanged.
- Arithmetic: PC wraps modulo 2^PC_W. The Adder provides this wrap (8'hFF+1 -> 8'h00); the block adds no saturation.
- oAdderA and oAdderB are combinational from PC and a constant. The other outputs are registered.
- Latency: one ack per cycle in the best case, giving back-to-back sequential fetches at 1 instruction per clock.

Decomposition:
- Shared package: state encoding (BOOT, FETCH, STALL, ERR) and the redirect-priority constants. The default PC_W and RESET_VECTOR also belong in the core-wide package shared with the Adder.
- Sub-module: pc_return_stack, a LIFO with push/pop/full/empty outputs and the err logic. The sequencer FSM and PC register stay in pc_sequencer.

Test Plan:
- Reset, then ack held high for 4 cycles -> oPC sequence 00,01,02,03,04. oInstrValid high from the cycle after the first ack. oAdderA tracks oPC and oAdderB=1.
- PC=8'hFE, two sequential acks -> PC goes FF then 00 (wrap). No error.
- Ack with iBranch=1 and iTarget=8'h40 -> PC=40. Ack with iCall=1, iTarget=8'h80 at PC=40 -> push 41, PC=80. Ack with iRet=1 -> PC=41, stack empty.
- Ack with iRet=1, iCall=1 and iBranch=1 together, stack holding 8'h12 -> PC=12, and no push occurs. Ack with iRet=1 on an empty stack -> oStackErr=1, ERR state, oFetchReq=0 until rst.
- 5 consecutive calls with STACK_DEPTH=4 -> the 5th call sets oStackErr, and PC stays at the 5th call's address.
- iStall raised mid-FETCH without ack -> oFetchReq drops next cycle, and acks received in STALL are ignored. Release -> request resumes at the same oPC. Asserting rst during STALL -> PC=00, state BOOT.
